// File: rtl/alu_seq.sv
// Sequential ALU with a start/ready/done handshake: single-cycle logic/add/sub,
// and an iterative shift-add multiplier that takes WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   OUT
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [RW-1:0]      mcand;
    logic [WIDTH-1:0]   mplier;
    logic [RW-1:0]      acc;
    logic [RW-1:0]      acc_next;
    logic [RW-1:0]      a_ext;
    logic [RW-1:0]      b_ext;
    logic [RW-1:0]      op_result;
    logic               op_rsv;
    logic               accept;
    logic               last_step;

    // Subtraction in the 2*WIDTH domain gives the two's-complement wrap for A<B.
    function automatic logic [RW-1:0] single_op(input logic [2:0] op,
                                               input logic [RW-1:0] a,
                                               input logic [RW-1:0] b);
        logic [RW-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SUB:  r = a - b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign a_ext     = {{WIDTH{1'b0}}, A};
    assign b_ext     = {{WIDTH{1'b0}}, B};
    assign op_result = single_op(opcode, a_ext, b_ext);
    assign op_rsv    = opcode[2] & opcode[1];
    assign ready     = (state == IDLE);
    assign accept    = ready & op_start;
    assign last_step = (state == MULT) && (cnt == CNT_W'(WIDTH - 1));

    // Multiplicand shifts left and multiplier shifts right each step, so bit 0 of
    // mplier is always the current multiplier bit and mcand is already aligned.
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && opcode == OP_MUL) state_next = MULT;
            MULT: if (last_step)                  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            OUT    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= a_ext;
                        mplier <= B;
                    end else begin
                        OUT  <= op_result;
                        err  <= op_rsv;
                        done <= 1'b1;
                    end
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                if (last_step) begin
                    OUT  <= acc_next;
                    err  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized traffic, all checked
// every cycle against a transaction-level model (busy countdown + plain arithmetic).
module tb_alu_seq;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            op_start = 1'b0;
    logic [W-1:0]    A = '0;
    logic [W-1:0]    B = '0;
    logic [2:0]      opcode = '0;
    logic            ready;
    logic            done;
    logic            err;
    logic [2*W-1:0]  OUT;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .A(A), .B(B), .opcode(opcode),
        .ready(ready), .done(done), .err(err), .OUT(OUT)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int              busy;
    logic [2*W-1:0]  pend;
    logic [2*W-1:0]  exp_out;
    logic            exp_done;
    logic            exp_err;

    function automatic logic [2*W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [2*W-1:0] x;
        logic [2*W-1:0] y;
        x = {{W{1'b0}}, a};
        y = {{W{1'b0}}, b};
        case (op)
            3'd0: return x + y;
            3'd1: return x * y;
            3'd2: return x | y;
            3'd3: return x & y;
            3'd4: return x ^ y;
            3'd5: return x - y;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 0;
            pend     <= '0;
            exp_out  <= '0;
            exp_done <= 1'b0;
            exp_err  <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            if (busy == 0) begin
                if (op_start) begin
                    if (opcode == 3'd1) begin
                        busy <= W;
                        pend <= ref_op(opcode, A, B);
                    end else begin
                        exp_out  <= ref_op(opcode, A, B);
                        exp_err  <= (opcode >= 3'd6);
                        exp_done <= 1'b1;
                    end
                end
            end else begin
                busy <= busy - 1;
                if (busy == 1) begin
                    exp_out  <= pend;
                    exp_err  <= 1'b0;
                    exp_done <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("ready", 32'(ready), 32'(busy == 0));
            chk("done", 32'(done), 32'(exp_done));
            chk("out", 32'(OUT), 32'(exp_out));
            if (exp_done) chk("err", 32'(err), 32'(exp_err));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_start = 1'b1; opcode = op; A = a; B = b;
        @(negedge clk);
        op_start = 1'b0; A = $urandom; B = $urandom; opcode = 3'($urandom);
    endtask

    // Waits (bounded) for done after a MUL was issued; returns ready-low cycles.
    task automatic wait_done(input string name, output int low_cycles);
        int n;
        low_cycles = 0;
        n = 0;
        while (!done && n < 20) begin
            if (!ready) low_cycles++;
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic pin(input string name, input logic [2*W-1:0] lit);
        chk({name, "_dut"}, 32'(OUT), 32'(lit));
        chk({name, "_model"}, 32'(exp_out), 32'(lit));
    endtask

    int lows;
    int dones;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out", 32'(OUT), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        rst = 1'b0;

        issue(3'd0, 8'hFF, 8'hFF);
        pin("add_ff", 16'h01FE);
        chk("add_ff_done", 32'(done), 32'd1);
        chk("add_ff_err", 32'(err), 32'd0);

        issue(3'd1, 8'hFF, 8'hFF);
        wait_done("mul_ff", lows);
        chk("mul_ff_ready_low", 32'(lows), 32'd8);
        pin("mul_ff", 16'hFE01);

        issue(3'd1, 8'h00, 8'h5A);
        wait_done("mul_0", lows);
        pin("mul_0", 16'h0000);

        issue(3'd1, 8'h01, 8'h80);
        wait_done("mul_1x80", lows);
        pin("mul_1x80", 16'h0080);

        issue(3'd5, 8'd3, 8'd5);
        pin("sub_wrap", 16'hFFFE);

        issue(3'd4, 8'hF0, 8'hFF);
        pin("xor", 16'h000F);

        // Back-to-back ADD then OR
        @(negedge clk);
        op_start = 1'b1; opcode = 3'd0; A = 8'h80; B = 8'h81;
        @(negedge clk);
        pin("b2b_add", 16'h0101);
        chk("b2b_add_done", 32'(done), 32'd1);
        opcode = 3'd2; A = 8'h0C; B = 8'h30;
        @(negedge clk);
        op_start = 1'b0;
        pin("b2b_or", 16'h003C);
        chk("b2b_or_done", 32'(done), 32'd1);

        // MUL with an ADD request during MULT that must be ignored
        issue(3'd1, 8'd3, 8'd4);
        op_start = 1'b1; opcode = 3'd0; A = 8'h11; B = 8'h22;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            if (done) dones++;
            if (i == 3) op_start = 1'b0;
            @(negedge clk);
        end
        if (done) dones++;
        chk("mul_ign_dones", 32'(dones), 32'd1);
        pin("mul_ign", 16'h000C);

        // Reset four cycles into MULT
        issue(3'd1, 8'hAB, 8'hCD);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(ready), 32'd1);
        chk("rst_mid_out", 32'(OUT), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 32'd0);
        pin("rst_mid", 16'h0000);

        issue(3'd7, 8'd1, 8'd1);
        pin("rsv", 16'h0000);
        chk("rsv_err", 32'(err), 32'd1);
        issue(3'd0, 8'd1, 8'd1);
        chk("after_rsv_err", 32'(err), 32'd0);
        pin("after_rsv", 16'h0002);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            op_start = ($urandom_range(0, 1) == 1);
            opcode   = ($urandom_range(0, 3) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
            A        = ($urandom_range(0, 7) == 0) ? 8'hFF : W'($urandom);
            B        = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; op_start = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
